bus_unit: RTL and testbench
===========================

# bus_unit

Bus interface unit for the t8086 core: the initiator side of the byte-wide memory port, driving the RAM's read and write enables, addresses and write data, and sampling its combinational read data. It serves byte/word data requests from the execution unit and fills an instruction prefetch queue from a prefetch pointer in otherwise idle bus cycles. It sits between the execution/decode logic and the RAM.

## Interface
- `DEPTH`, 6: prefetch queue depth in bytes.
- `RESET_PC`, 20'hFFFF0: prefetch pointer value after reset.
- `clk`  in  1  single clock, all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  data request present.
- `req_ready`  out  1  unit can accept a request (state IDLE).
- `req_we`  in  1  1 = write, 0 = read.
- `req_word`  in  1  1 = 16-bit access, 0 = byte.
- `req_addr`  in  20  physical byte address.
- `req_wdata`  in  16  write data, low byte used for byte writes.
- `rsp_valid`  out  1  one-cycle completion pulse (reads and writes).
- `rsp_rdata`  out  16  read data; byte reads zero-extend; 0 for writes.
- `flush`  in  1  discard queue, restart prefetch at `flush_addr`.
- `flush_addr`  in  20  new prefetch pointer.
- `q_valid`  out  1  queue non-empty.
- `q_data`  out  8  head byte of queue.
- `q_pop`  in  1  consume head byte.
- `ram_rd_en`  out  1  RAM read enable.
- `ram_rd_addr`  out  20  RAM read address.
- `ram_rd_data`  in  8  RAM read data, combinational in same cycle.
- `ram_wr_en`  out  1  RAM write enable.
- `ram_wr_addr`  out  20  RAM write address.
- `ram_wr_data`  out  8  RAM write byte.

## Operation
- FSM states: IDLE, D_LO, D_HI. Request latched on posedge with `req_valid && req_ready` → D_LO.
- D_LO: access byte at latched addr (read: `ram_rd_en`, sample `ram_rd_data` into rdata[7:0]; write: `ram_wr_en`, data = wdata[7:0]). Word → D_HI, else → IDLE.
- D_HI: address = addr+1 mod 2^20 (FFFFF → 00000); read into rdata[15:8] or write wdata[15:8]; → IDLE.
- `rsp_valid` registered: pulses in the cycle after the final byte cycle. No response backpressure.
- Prefetch: only in IDLE, and only when count < DEPTH and `flush` low. Drives `ram_rd_en`, `ram_rd_addr` = pf_ptr; byte pushed and pf_ptr incremented (mod 2^20) at the edge. Prefetch runs in the same IDLE cycle in which a request is accepted.
- Data accesses always win the bus; no prefetch in D_LO/D_HI.
- Queue: circular, head/tail pointers, count 0..DEPTH. `q_pop` when empty is ignored. Push and pop in the same cycle leave count unchanged.
- Flush: count ← 0, pf_ptr ← `flush_addr`. Any same-cycle prefetch byte and `q_pop` are discarded. An in-flight data access is unaffected.
- Writes do not snoop the queue. Stale prefetched bytes are the decoder's responsibility, via flush.
- `ram_*` outputs are combinational from registered state. `ram_wr_en` and `ram_rd_en` are never both high.

## Timing
- Reset (async, `rst_n` low): state IDLE, count 0, pf_ptr = `RESET_PC`, `rsp_valid` 0, `rsp_rdata` 0, `q_valid` 0, and every `ram_*` output 0, forced while `rst_n` is low.
- Byte request accepted at edge N: bus cycle N+1, `rsp_valid` in N+2, `req_ready` high again in N+2.
- Word request accepted at edge N: bus cycles N+1 and N+2, `rsp_valid` in N+3.
- Reset asserted mid-request: request dropped, no response.
- Prefetch throughput: 1 byte/cycle while idle and not full.

## Structure
- Package `t8086_bus_pkg` holds the FSM state enum and `RESET_PC`.
- Sub-module `prefetch_queue` is the circular FIFO (push/pop/flush, count, head data). The FSM and bus muxing live in `bus_unit`.

## Test plan
- Reset release, RAM FFFF0..FFFF5 = 01..06 → `ram_rd_addr` steps FFFF0..FFFF5 over 6 cycles; `q_valid` high, `q_data` = 01; `ram_rd_en` drops when count = 6.
- Word read at FFFFF, mem[FFFFF]=AB, mem[00000]=CD → reads FFFFF then 00000; `rsp_rdata` = CDAB with `rsp_valid` 3 cycles after accept.
- Word write 1234 to 00100 → cycle 1 `ram_wr_addr` 00100 data 34, cycle 2 00101 data 12; `rsp_valid` cycle 3 with rdata 0000; no prefetch in cycles 1-2.
- `flush` (`flush_addr` 00200) in the same cycle as `q_pop`, with count 4 → count 0, `q_valid` low next cycle; next prefetch address 00200.
- Byte read accepted with queue count 5 → prefetch fills slot 6 in the accept cycle, D_LO reads the request addr; `rsp_rdata` = 00xx; queue holds 6.
- `rst_n` pulsed low during D_HI → all outputs 0 immediately; no `rsp_valid`; prefetch restarts at FFFF0.

Source files
------------

// File: rtl/bus_unit_pkg.sv
// Shared types and constants for the t8086 bus interface unit.
package t8086_bus_pkg;

  localparam int ADDR_W = 20;
  localparam logic [ADDR_W-1:0] RESET_PC = 20'hFFFF0;

  typedef enum logic [1:0] {
    IDLE,
    D_LO,
    D_HI
  } bus_state_e;

endpackage

// File: rtl/bus_unit_if.sv
// Execution-unit request/response, prefetch queue and RAM port signals of the bus unit.
interface bus_unit_if;
  import t8086_bus_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_word;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;
  logic              rsp_valid;
  logic [15:0]       rsp_rdata;
  logic              flush;
  logic [ADDR_W-1:0] flush_addr;
  logic              q_valid;
  logic [7:0]        q_data;
  logic              q_pop;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [7:0]        ram_rd_data;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [7:0]        ram_wr_data;

  // The execution unit and RAM side together.
  modport master (
    output req_valid, req_we, req_word, req_addr, req_wdata, flush, flush_addr, q_pop,
           ram_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, q_valid, q_data,
           ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data
  );

  modport slave (
    input  req_valid, req_we, req_word, req_addr, req_wdata, flush, flush_addr, q_pop,
           ram_rd_data,
    output req_ready, rsp_valid, rsp_rdata, q_valid, q_data,
           ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/bus_unit_prefetch_queue.sv
// Circular byte FIFO holding prefetched instruction bytes; flush empties it.
module prefetch_queue #(
  parameter int DEPTH = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_push_data,
  input  logic       i_pop,
  input  logic       i_flush,
  output logic       o_full,
  output logic       o_valid,
  output logic [7:0] o_head
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_head] : 8'h00;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && o_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= next_ptr(r_tail);
      if (w_pop)  r_head <= next_ptr(r_head);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // NOTE: storage has no reset; r_count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_tail] <= i_push_data;
  end

endmodule

// File: rtl/bus_unit.sv
// t8086 bus interface unit: byte/word data accesses on the byte-wide RAM port,
// with instruction prefetch into a small queue whenever the bus is otherwise idle.
module bus_unit
  import t8086_bus_pkg::*;
#(
  parameter int                DEPTH    = 6,
  parameter logic [ADDR_W-1:0] RESET_PC = t8086_bus_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  bus_unit_if.slave   bus
);

  bus_state_e        r_state;
  logic              r_we;
  logic              r_word;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic [15:0]       r_rdata;
  logic              r_rsp_valid;
  logic [ADDR_W-1:0] r_pf_ptr;

  logic              w_req_ready;
  logic              w_accept;
  logic              w_q_full;
  logic              w_pf_en;
  logic              w_data_rd;
  logic              w_data_wr;
  logic [ADDR_W-1:0] w_bus_addr;

  assign w_req_ready = rst_n && (r_state == IDLE);
  assign w_accept    = bus.req_valid && w_req_ready;
  // Data accesses own the bus outside IDLE, so prefetch is confined to IDLE.
  assign w_pf_en     = rst_n && (r_state == IDLE) && !w_q_full && !bus.flush;
  assign w_data_rd   = (r_state != IDLE) && !r_we;
  assign w_data_wr   = (r_state != IDLE) && r_we;
  assign w_bus_addr  = (r_state == D_HI) ? r_addr + ADDR_W'(1) : r_addr;

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    bus.ram_rd_en   = 1'b0;
    bus.ram_rd_addr = '0;
    bus.ram_wr_en   = 1'b0;
    bus.ram_wr_addr = '0;
    bus.ram_wr_data = 8'h00;
    if (rst_n) begin
      if (w_data_rd) begin
        bus.ram_rd_en   = 1'b1;
        bus.ram_rd_addr = w_bus_addr;
      end else if (w_pf_en) begin
        bus.ram_rd_en   = 1'b1;
        bus.ram_rd_addr = r_pf_ptr;
      end
      if (w_data_wr) begin
        bus.ram_wr_en   = 1'b1;
        bus.ram_wr_addr = w_bus_addr;
        bus.ram_wr_data = (r_state == D_HI) ? r_wdata[15:8] : r_wdata[7:0];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_word      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 16'h0000;
      r_rdata     <= 16'h0000;
      r_rsp_valid <= 1'b0;
      r_pf_ptr    <= RESET_PC;
    end else begin
      r_rsp_valid <= 1'b0;
      if (bus.flush)   r_pf_ptr <= bus.flush_addr;
      else if (w_pf_en) r_pf_ptr <= r_pf_ptr + ADDR_W'(1);

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we    <= bus.req_we;
            r_word  <= bus.req_word;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_rdata <= 16'h0000;
            r_state <= D_LO;
          end
        end
        D_LO: begin
          if (!r_we) r_rdata[7:0] <= bus.ram_rd_data;
          if (r_word) begin
            r_state <= D_HI;
          end else begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b1;
          end
        end
        D_HI: begin
          if (!r_we) r_rdata[15:8] <= bus.ram_rd_data;
          r_state     <= IDLE;
          r_rsp_valid <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  prefetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_pf_en),
    .i_push_data (bus.ram_rd_data),
    .i_pop       (bus.q_pop),
    .i_flush     (bus.flush),
    .o_full      (w_q_full),
    .o_valid     (bus.q_valid),
    .o_head      (bus.q_data)
  );

endmodule

// File: tb/tb_bus_unit.sv
// Directed bench for bus_unit: prefetch fill, word wrap read, word write, flush, reset mid-access.
module tb_bus_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  bit [7:0] mem [2**20];

  bus_unit_if bus_if ();

  bus_unit #(.DEPTH(6), .RESET_PC(20'hFFFF0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  assign bus_if.ram_rd_data = mem[bus_if.ram_rd_addr];

  always @(posedge clk) begin
    if (bus_if.ram_wr_en) mem[bus_if.ram_wr_addr] <= bus_if.ram_wr_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 6; i++) mem[20'hFFFF0 + i] = 8'(i + 1);
    for (int i = 0; i < 6; i++) mem[20'h00200 + i] = 8'hA0 + 8'(i);
    mem[20'hFFFFF] = 8'hAB;
    mem[20'h00000] = 8'hCD;

    bus_if.req_valid  = 1'b0;
    bus_if.req_we     = 1'b0;
    bus_if.req_word   = 1'b0;
    bus_if.req_addr   = '0;
    bus_if.req_wdata  = '0;
    bus_if.flush      = 1'b0;
    bus_if.flush_addr = '0;
    bus_if.q_pop      = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_rd_en",   32'(bus_if.ram_rd_en),   32'h0);
    check("rst_rd_addr", 32'(bus_if.ram_rd_addr), 32'h0);
    check("rst_wr_en",   32'(bus_if.ram_wr_en),   32'h0);
    check("rst_rsp_vld", 32'(bus_if.rsp_valid),   32'h0);
    check("rst_q_valid", 32'(bus_if.q_valid),     32'h0);

    // Prefetch fill after reset release
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      check("pf_rd_en",   32'(bus_if.ram_rd_en),   32'h1);
      check("pf_rd_addr", 32'(bus_if.ram_rd_addr), 32'hFFFF0 + 32'(i));
      step();
    end
    check("pf_full_rd_en", 32'(bus_if.ram_rd_en), 32'h0);
    check("pf_q_valid",    32'(bus_if.q_valid),   32'h1);
    check("pf_q_data",     32'(bus_if.q_data),    32'h01);

    // Word read wrapping FFFFF -> 00000
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = 1'b0;
    bus_if.req_word  = 1'b1;
    bus_if.req_addr  = 20'hFFFFF;
    #1;
    check("wr_rd_ready", 32'(bus_if.req_ready), 32'h1);
    step();
    bus_if.req_valid = 1'b0;
    check("wrd_lo_addr",  32'(bus_if.ram_rd_addr), 32'hFFFFF);
    check("wrd_lo_ready", 32'(bus_if.req_ready),   32'h0);
    step();
    check("wrd_hi_addr",  32'(bus_if.ram_rd_addr), 32'h00000);
    check("wrd_hi_rsp",   32'(bus_if.rsp_valid),   32'h0);
    step();
    check("wrd_rsp_vld",  32'(bus_if.rsp_valid),   32'h1);
    check("wrd_rsp_data", 32'(bus_if.rsp_rdata),   32'hCDAB);
    check("wrd_ready",    32'(bus_if.req_ready),   32'h1);
    check("wrd_idle_pf",  32'(bus_if.ram_rd_en),   32'h0);
    step();
    check("wrd_rsp_drop", 32'(bus_if.rsp_valid),   32'h0);

    // Word write 1234 to 00100, popping one byte in the accept cycle
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = 1'b1;
    bus_if.req_word  = 1'b1;
    bus_if.req_addr  = 20'h00100;
    bus_if.req_wdata = 16'h1234;
    bus_if.q_pop     = 1'b1;
    #1;
    check("ww_head", 32'(bus_if.q_data), 32'h01);
    step();
    bus_if.req_valid = 1'b0;
    bus_if.q_pop     = 1'b0;
    #1;
    check("ww_lo_en",   32'(bus_if.ram_wr_en),   32'h1);
    check("ww_lo_addr", 32'(bus_if.ram_wr_addr), 32'h00100);
    check("ww_lo_data", 32'(bus_if.ram_wr_data), 32'h34);
    check("ww_lo_nopf", 32'(bus_if.ram_rd_en),   32'h0);
    step();
    check("ww_hi_en",   32'(bus_if.ram_wr_en),   32'h1);
    check("ww_hi_addr", 32'(bus_if.ram_wr_addr), 32'h00101);
    check("ww_hi_data", 32'(bus_if.ram_wr_data), 32'h12);
    check("ww_hi_nopf", 32'(bus_if.ram_rd_en),   32'h0);
    step();
    check("ww_rsp_vld", 32'(bus_if.rsp_valid),   32'h1);
    check("ww_rsp_data",32'(bus_if.rsp_rdata),   32'h0000);
    check("ww_mem_lo",  32'(mem[20'h00100]),     32'h34);
    check("ww_mem_hi",  32'(mem[20'h00101]),     32'h12);
    check("ww_q_head",  32'(bus_if.q_data),      32'h02);
    check("ww_pf_addr", 32'(bus_if.ram_rd_addr), 32'hFFFF6);
    step();

    // Word read 00100 while popping; flush with pop at count 4 during D_HI
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = 1'b0;
    bus_if.req_word  = 1'b1;
    bus_if.req_addr  = 20'h00100;
    bus_if.q_pop     = 1'b1;
    step();
    bus_if.req_valid = 1'b0;
    check("fl_lo_addr", 32'(bus_if.ram_rd_addr), 32'h00100);
    step();
    bus_if.flush      = 1'b1;
    bus_if.flush_addr = 20'h00200;
    #1;
    check("fl_hi_addr", 32'(bus_if.ram_rd_addr), 32'h00101);
    check("fl_q_valid", 32'(bus_if.q_valid),     32'h1);
    step();
    bus_if.flush = 1'b0;
    bus_if.q_pop = 1'b0;
    #1;
    check("fl_q_empty", 32'(bus_if.q_valid),     32'h0);
    check("fl_rsp_vld", 32'(bus_if.rsp_valid),   32'h1);
    check("fl_rsp_data",32'(bus_if.rsp_rdata),   32'h1234);
    check("fl_pf_en",   32'(bus_if.ram_rd_en),   32'h1);
    check("fl_pf_addr", 32'(bus_if.ram_rd_addr), 32'h00200);

    // Refill to 5, then byte read accepted while the last slot fills
    repeat (5) step();
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = 1'b0;
    bus_if.req_word  = 1'b0;
    bus_if.req_addr  = 20'h00100;
    #1;
    check("br_pf_addr", 32'(bus_if.ram_rd_addr), 32'h00205);
    step();
    bus_if.req_valid = 1'b0;
    check("br_lo_addr", 32'(bus_if.ram_rd_addr), 32'h00100);
    step();
    check("br_rsp_vld", 32'(bus_if.rsp_valid),   32'h1);
    check("br_rsp_data",32'(bus_if.rsp_rdata),   32'h0034);
    check("br_ready",   32'(bus_if.req_ready),   32'h1);
    check("br_full",    32'(bus_if.ram_rd_en),   32'h0);
    bus_if.q_pop = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("br_q_data", 32'(bus_if.q_data), 32'hA0 + 32'(i));
      step();
    end
    bus_if.q_pop = 1'b0;

    // Reset pulsed during D_HI of a word read
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = 1'b0;
    bus_if.req_word  = 1'b1;
    bus_if.req_addr  = 20'h00000;
    step();
    bus_if.req_valid = 1'b0;
    step();
    check("rm_hi_addr", 32'(bus_if.ram_rd_addr), 32'h00001);
    rst_n = 1'b0;
    #1;
    check("rm_rd_en",   32'(bus_if.ram_rd_en),   32'h0);
    check("rm_rd_addr", 32'(bus_if.ram_rd_addr), 32'h0);
    check("rm_wr_en",   32'(bus_if.ram_wr_en),   32'h0);
    check("rm_ready",   32'(bus_if.req_ready),   32'h0);
    check("rm_q_valid", 32'(bus_if.q_valid),     32'h0);
    check("rm_q_data",  32'(bus_if.q_data),      32'h0);
    check("rm_rsp_vld", 32'(bus_if.rsp_valid),   32'h0);
    check("rm_rsp_data",32'(bus_if.rsp_rdata),   32'h0);
    step();
    rst_n = 1'b1;
    #1;
    check("rm_pf_addr0", 32'(bus_if.ram_rd_addr), 32'hFFFF0);
    check("rm_rsp_none0",32'(bus_if.rsp_valid),   32'h0);
    check("rm_ready1",   32'(bus_if.req_ready),   32'h1);
    step();
    check("rm_pf_addr1", 32'(bus_if.ram_rd_addr), 32'hFFFF1);
    check("rm_rsp_none1",32'(bus_if.rsp_valid),   32'h0);
    check("rm_q_head",   32'(bus_if.q_data),      32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
